acc_uart_bridge: RTL and testbench

- Parametrised successor to the accumulator-to-UART interface.
- Buffers DATA_W-bit words from the processor (DATA_IN/WR strobe) in a synchronous FIFO.
- Splits each word into DATA_W/8 bytes and sends each byte as an 8N1/8N2 UART frame on TX.
- Adds configurable word width, FIFO depth, baud divisor, stop bits, byte order, status flags and a sticky overflow flag.

---
 rtl/acc_uart_bridge.sv | 164 ++++++++++++++++
 tb/tb_acc_uart_bridge.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/acc_uart_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | acc_uart_bridge: word FIFO feeding a byte-wise 8N1/8N2 UART transmitter.   |
// | Optional even parity bit per frame when ACC_UART_PARITY_EN is defined.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module acc_uart_bridge #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int MSB_FIRST    = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic              WR,
  output logic              TX,
  output logic              FULL,
  output logic              EMPTY,
  output logic              BUSY,
  output logic              OVERFLOW
);

  localparam int NB    = DATA_W / 8;
  localparam int BW    = (NB > 1) ? $clog2(NB) : 1;
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int AW1   = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef ACC_UART_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd5;
`endif

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wptr_q, rptr_q;
  logic [AW1-1:0]    count_q, count_d;
  logic              full_q, empty_q, ovf_q;
  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     baud_q;
  logic [2:0]        bit_q;
  logic [BW-1:0]     byte_q;
  logic [DATA_W-1:0] word_q;

  logic              w_push, w_pop, w_tick, w_last_stop, w_last_byte;
  logic [BW-1:0]     w_sel;
  logic [7:0]        w_byte;

  // FULL is the pre-pop value, so a write while full is dropped even on a pop cycle
  assign w_push      = WR & ~full_q;
  assign w_pop       = (state_q == S_LOAD);
  assign count_d     = count_q + AW1'(w_push) - AW1'(w_pop);
  assign w_tick      = (baud_q == CW'(CLKS_PER_BIT - 1));
  assign w_last_stop = (bit_q == 3'(STOP_BITS - 1));
  assign w_last_byte = (byte_q == BW'(NB - 1));
  assign w_sel       = (MSB_FIRST != 0) ? (BW'(NB - 1) - byte_q) : byte_q;
  assign w_byte      = 8'(word_q >> {w_sel, 3'b000});

  always_ff @(posedge CLK) begin
    if (w_push) begin
      mem_q[wptr_q] <= DATA_IN;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      if (w_push) wptr_q <= wptr_q + ADDR_W'(1);
      if (w_pop)  rptr_q <= rptr_q + ADDR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == AW1'(DEPTH));
      empty_q <= (count_d == '0);
      if (WR && full_q) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!empty_q) state_d = S_LOAD;
      S_LOAD:  state_d = S_START;
      S_START: if (w_tick) state_d = S_DATA;
      S_DATA: begin
        if (w_tick && bit_q == 3'd7) begin
`ifdef ACC_UART_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef ACC_UART_PARITY_EN
      S_PARITY: if (w_tick) state_d = S_STOP;
`endif
      S_STOP: begin
        if (w_tick && w_last_stop) begin
          if (!w_last_byte)  state_d = S_START;
          else if (!empty_q) state_d = S_LOAD;
          else               state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // bit_q counts data bits in DATA and stop bit-times in STOP; any state change clears it
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      baud_q <= '0;
      bit_q  <= '0;
      byte_q <= '0;
      word_q <= '0;
    end else begin
      if (state_q == S_IDLE || state_q == S_LOAD || w_tick) baud_q <= '0;
      else                                                  baud_q <= baud_q + CW'(1);
      if (state_d != state_q) bit_q <= '0;
      else if (w_tick)        bit_q <= bit_q + 3'd1;
      if (w_pop) begin
        word_q <= mem_q[rptr_q];
        byte_q <= '0;
      end else if (state_q == S_STOP && state_d == S_START) begin
        byte_q <= byte_q + BW'(1);
      end
    end
  end

  always_comb begin
    TX   = 1'b1;
    BUSY = (state_q != S_IDLE);
    case (state_q)
      S_START:  TX = 1'b0;
      S_DATA:   TX = w_byte[bit_q];
`ifdef ACC_UART_PARITY_EN
      S_PARITY: TX = ^w_byte;
`endif
      default:  TX = 1'b1;
    endcase
  end

  assign FULL     = full_q;
  assign EMPTY    = empty_q;
  assign OVERFLOW = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_acc_uart_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_acc_uart_bridge: self-checking bench for acc_uart_bridge (LSB-first and |
// | MSB-first instances, 16-bit words, 4-deep FIFO, 4 clocks per bit).         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_acc_uart_bridge;

  localparam int CPB = 4;
`ifdef ACC_UART_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FT = (10 + PAR) * CPB;  // one frame, one stop bit
  localparam int WT = 2 * FT;            // one 16-bit word

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] din_a = '0, din_b = '0;
  logic        wr_a = 1'b0, wr_b = 1'b0;
  logic        tx_a, full_a, empty_a, busy_a, ovf_a;
  logic        tx_b, full_b, empty_b, busy_b, ovf_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  acc_uart_bridge #(.DATA_W(16), .ADDR_W(2), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .MSB_FIRST(0)) u_dut_a (
    .CLK(clk), .RESET(rst), .DATA_IN(din_a), .WR(wr_a),
    .TX(tx_a), .FULL(full_a), .EMPTY(empty_a), .BUSY(busy_a), .OVERFLOW(ovf_a)
  );

  acc_uart_bridge #(.DATA_W(16), .ADDR_W(2), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .MSB_FIRST(1)) u_dut_b (
    .CLK(clk), .RESET(rst), .DATA_IN(din_b), .WR(wr_b),
    .TX(tx_b), .FULL(full_b), .EMPTY(empty_b), .BUSY(busy_b), .OVERFLOW(ovf_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] stat(input bit sel);
    return sel ? {tx_b, full_b, empty_b, busy_b, ovf_b} : {tx_a, full_a, empty_a, busy_a, ovf_a};
  endfunction

  task automatic drive(input bit sel, input logic w, input logic [15:0] d);
    if (sel) begin wr_b = w; din_b = d; end
    else     begin wr_a = w; din_a = d; end
  endtask

  // Expected TX level i cycles after the start bit of a word begins
  function automatic logic exp_bit(input logic [15:0] w, input bit msb, input int i);
    int f, b;
    logic [7:0] by;
    f  = i / FT;
    b  = (i % FT) / CPB;
    by = 8'(w >> (8 * (msb ? 1 - f : f)));
    if (b == 0) return 1'b0;
    if (b <= 8) return by[b-1];
    if (PAR == 1 && b == 9) return ^by;
    return 1'b1;
  endfunction

  // Writes wq on consecutive cycles; the first nexp words must appear back to back on TX
  task automatic run_seq(input bit sel, input logic [15:0] wq[$], input int nexp, input string tag);
    int err, L, j, r;
    logic e;
    logic [4:0] s;
    err = 0;
    L   = nexp * (WT + 1) - 1;
    @(negedge clk);
    drive(sel, 1'b1, wq[0]);
    for (int c = 0; c <= L + 2; c++) begin
      @(negedge clk);
      if (c + 1 < wq.size()) drive(sel, 1'b1, wq[c+1]);
      else                   drive(sel, 1'b0, 16'h0);
      s = stat(sel);
      if (c == 0) chk({tag, " empty_fall"}, 32'(s[2]), 32'd0);
      if (c == 1) chk({tag, " load_cycle"}, 32'({s[1], s[4]}), 32'd3);
      if (c == 4 && wq.size() >= 5) chk({tag, " full"}, 32'(s[3]), 32'd1);
      if (c == 5 && wq.size() >= 6) chk({tag, " overflow_set"}, 32'(s[0]), 32'd1);
      if (c >= 2 && c - 2 < L) begin
        j = (c - 2) / (WT + 1);
        r = (c - 2) % (WT + 1);
        e = (r == WT) ? 1'b1 : exp_bit(wq[j], sel, r);
        if (s[4] !== e) err++;
      end
    end
    s = stat(sel);
    chk({tag, " wave_errs"}, 32'(err), 32'd0);
    chk({tag, " end_idle"}, 32'({s[1], s[2], s[4]}), 32'b011);
    chk({tag, " overflow_flag"}, 32'(s[0]), 32'(wq.size() > nexp));
  endtask

  task automatic rx_byte(input bit sel, output logic [7:0] b, output bit ok);
    logic [4:0] s;
    ok = 1'b0;
    b  = '0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      s = stat(sel);
      if (s[4] == 1'b0) begin ok = 1'b1; break; end
    end
    if (!ok) return;
    repeat (CPB + CPB / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      s = stat(sel);
      b[i] = s[4];
      if (i < 7) repeat (CPB) @(negedge clk);
    end
    if (PAR == 1) begin
      repeat (CPB) @(negedge clk);
      s = stat(sel);
      if (s[4] !== ^b) ok = 1'b0;
    end
    repeat (CPB) @(negedge clk);
    s = stat(sel);
    if (s[4] !== 1'b1) ok = 1'b0;
  endtask

  task automatic reset_mid(input logic [15:0] w1, input logic [15:0] w2, input string tag);
    int err;
    logic [4:0] s;
    err = 0;
    @(negedge clk); drive(0, 1'b1, w1);
    @(negedge clk); drive(0, 1'b1, w2);
    @(negedge clk); drive(0, 1'b0, 16'h0);
    repeat (14) @(negedge clk);
    s = stat(0);
    chk({tag, " pre_reset_bit"}, 32'(s[4]), 32'(exp_bit(w1, 1'b0, 13)));
    #1 rst = 1'b1;
    #1 s = stat(0);
    chk({tag, " async_reset"}, 32'(s), 32'b10100);
    @(negedge clk) rst = 1'b0;
    for (int c = 0; c < 3 * WT; c++) begin
      @(negedge clk);
      s = stat(0);
      if (s[4] !== 1'b1 || s[1] !== 1'b0) err++;
    end
    chk({tag, " no_residual"}, 32'(err), 32'd0);
  endtask

  typedef struct {
    bit          sel;
    logic [15:0] w;
    logic [7:0]  b0;
    logic [7:0]  b1;
  } vec_t;

  initial begin
    vec_t        vt[6];
    logic [15:0] q[$];
    logic [7:0]  rb;
    bit          ok;
    logic [4:0]  s;
    int          k;
    bit          sel;

    vt[0] = '{0, 16'hA55A, 8'h5A, 8'hA5};
    vt[1] = '{0, 16'h1234, 8'h34, 8'h12};
    vt[2] = '{1, 16'h1234, 8'h12, 8'h34};
    vt[3] = '{1, 16'hA55A, 8'hA5, 8'h5A};
    vt[4] = '{0, 16'h8001, 8'h01, 8'h80};
    vt[5] = '{1, 16'h00FF, 8'h00, 8'hFF};

    repeat (3) @(negedge clk);
    chk("reset_a", 32'(stat(0)), 32'b10100);
    chk("reset_b", 32'(stat(1)), 32'b10100);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      drive(vt[i].sel, 1'b1, vt[i].w);
      @(negedge clk);
      drive(vt[i].sel, 1'b0, 16'h0);
      rx_byte(vt[i].sel, rb, ok);
      chk($sformatf("vec%0d_byte0", i), 32'({ok, rb}), 32'({1'b1, vt[i].b0}));
      rx_byte(vt[i].sel, rb, ok);
      chk($sformatf("vec%0d_byte1", i), 32'({ok, rb}), 32'({1'b1, vt[i].b1}));
      for (int t = 0; t < 100; t++) begin
        @(negedge clk);
        s = stat(vt[i].sel);
        if (s[1] == 1'b0) break;
      end
      chk($sformatf("vec%0d_idle", i), 32'(s[1]), 32'd0);
    end

    q.delete(); q.push_back(16'hA55A);
    run_seq(0, q, 1, "single");
    q.delete(); q.push_back(16'h1234);
    run_seq(1, q, 1, "msb_first");
    q.delete(); q.push_back(16'h0001); q.push_back(16'h0002);
    run_seq(0, q, 2, "back2back");
    q.delete();
    for (int i = 0; i < 6; i++) q.push_back(16'h1111 * 16'(i + 1));
    run_seq(0, q, 5, "overflow");

    reset_mid(16'hFFFF, 16'h1234, "rst_ffff");
    reset_mid(16'h0000, 16'hFFFF, "rst_0000");

    for (int it = 0; it < 6; it++) begin
      sel = 1'($urandom_range(0, 1));
      k   = int'($urandom_range(1, 4));
      q.delete();
      for (int i = 0; i < k; i++) q.push_back(16'($urandom));
      run_seq(sel, q, k, $sformatf("rand%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
